p2s_tx: RTL and testbench
=========================

P2S_TX -- requirements
Module: p2s_tx

Interface
REQ-001 Parameter PORT_WIDTH, default 8, meaning word width in bits; legal range 2..512.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pi  input  PORT_WIDTH  parallel word to transmit.
REQ-005 pi_valid  input  1  pi holds a word to be accepted.
REQ-006 pi_ready  output  1  block can accept a word this cycle; transfer occurs when pi_valid && pi_ready.
REQ-007 so  output  1  serial data, LSB first.
REQ-008 dat_en  output  1  frame enable, matching the team's serial-to-parallel receiver framing.
REQ-009 busy  output  1  high whenever a frame is in progress or a word is held.

Function
REQ-010 The block SHALL contain one shift register (SR) and one holding register (HR) with a valid flag, forming a 2-deep buffer.
REQ-011 pi_ready SHALL equal !HR_valid (combinational from state only, never from pi_valid).
REQ-012 An accepted word SHALL go to SR directly if the FSM is IDLE and HR is empty, otherwise to HR.
REQ-013 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-014 IDLE->SHIFT on the cycle after a word is loaded into SR; bit counter cleared to 0.
REQ-015 In SHIFT, so = SR[cnt] and dat_en = 1 for cnt = 0..PORT_WIDTH-1, one bit per cycle; after cnt = PORT_WIDTH-1 go to COMMIT.
REQ-016 In COMMIT, dat_en = 1 for exactly one cycle and so = 0 (parity variant: see REQ-027); this is the receiver's latch cycle.
REQ-017 COMMIT->SHIFT if HR_valid (HR moves to SR, HR_valid cleared in the same cycle), else COMMIT->IDLE.
REQ-018 A word accepted during COMMIT while HR is empty SHALL go straight to SR, giving back-to-back frames with dat_en continuously high.
REQ-019 Frame latency: a word accepted at edge N in IDLE SHALL drive bit 0 on so during the cycle after edge N+1. Each frame SHALL last exactly PORT_WIDTH+1 cycles of dat_en high.
REQ-020 In IDLE, dat_en = 0 and so = 0.
REQ-021 The bit counter SHALL be $clog2(PORT_WIDTH+1) bits wide and SHALL never exceed PORT_WIDTH-1.
REQ-022 so and dat_en SHALL be registered outputs.
REQ-023 pi SHALL be sampled only on an accepted transfer; changes at other times have no effect.

Reset
REQ-024 When rst_n is asserted low, the block SHALL set FSM = IDLE, cnt = 0, SR = 0, HR = 0, HR_valid = 0, so = 0, dat_en = 0, busy = 0 and pi_ready = 1.
REQ-025 Reset mid-frame SHALL abort the frame immediately and discard both the SR and HR contents. On the first edge after release, no dat_en pulse or stale bit SHALL appear.

Configuration
REQ-026 The macro P2S_PARITY_EN SHALL control the parity feature.
REQ-027 With P2S_PARITY_EN defined, so during COMMIT SHALL be the even parity (XOR) of the transmitted word.
REQ-028 Without P2S_PARITY_EN, so during COMMIT SHALL be 0 and no parity logic SHALL be present.
REQ-029 Frame timing SHALL be identical in both builds.

Structure
REQ-030 The shared package p2s_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2) and the default PORT_WIDTH constant.
REQ-031 The design SHALL be a single module with no sub-modules; the HR is small enough to stay inline.

Verification
REQ-032 Single word: send pi=8'hA5 once -> so sequence 1,0,1,0,0,1,0,1; dat_en high 9 cycles; the paired s2p receiver outputs po=8'hA5 on the 9th cycle.
REQ-033 Back-to-back: send 8'h3C, 8'hFF, 8'h00 with pi_valid held high -> dat_en high for 27 consecutive cycles; pi_ready low while HR is full; the receiver yields 3C, FF, 00 in order.
REQ-034 Backpressure: hold pi_valid high with 8'h81 during the first frame's SHIFT state -> HR fills and pi_ready drops; pi_ready rises in the cycle after COMMIT.
REQ-035 Reset mid-frame: assert rst_n at bit 4 of 8'hF0 with HR holding 8'h0F -> outputs are 0 immediately; after release, busy=0 and no further dat_en appears.
REQ-036 Parity build: send 8'h07 -> so=1 in COMMIT; send 8'h03 -> so=0 in COMMIT. Non-parity build: so=0 in COMMIT for both words.
REQ-037 Width sweep: run PORT_WIDTH=2 and PORT_WIDTH=16 with random words -> frame length is PORT_WIDTH+1 cycles and loopback through s2p matches.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_tx serialiser: FSM state encoding and default word width.
package p2s_pkg;

  localparam int P2S_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } p2s_state_e;

endpackage

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: 2-deep buffer (shift + holding register), LSB-first frames
// of PORT_WIDTH data cycles plus one commit cycle. Define P2S_PARITY_EN to send even parity on so during commit.
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int PORT_WIDTH = P2S_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] pi,
  input  logic                  pi_valid,
  output logic                  pi_ready,
  output logic                  so,
  output logic                  dat_en,
  output logic                  busy,
  output p2s_state_e            state_dbg
);

  localparam int CW = $clog2(PORT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PORT_WIDTH - 1);

  // Handshake: a word transfers on a rising edge where pi_valid && pi_ready; pi_ready depends
  // only on the holding register being empty, so it never waits on pi_valid.

  p2s_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PORT_WIDTH-1:0] sr_q, sr_d;
  logic [PORT_WIDTH-1:0] hr_q, hr_d;
  logic                  hr_valid_q, hr_valid_d;
  logic                  so_q, so_d;
  logic                  dat_en_q, dat_en_d;
  logic                  accept;
  logic                  cur_bit;
  logic                  commit_bit;

  assign pi_ready  = !hr_valid_q;
  assign accept    = pi_valid && pi_ready;
  assign so        = so_q;
  assign dat_en    = dat_en_q;
  // The commit cycle is still part of the frame even though the FSM has already left SHIFT.
  assign busy      = (state_q != ST_IDLE) || hr_valid_q || dat_en_q;
  assign state_dbg = state_q;

`ifdef P2S_PARITY_EN
  assign commit_bit = ^sr_q;
`else
  assign commit_bit = 1'b0;
`endif

  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < PORT_WIDTH; i++) begin
      if (cnt_q == CW'(i)) cur_bit = sr_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    hr_d       = hr_q;
    hr_valid_d = hr_valid_q;
    so_d       = 1'b0;
    dat_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d    = pi;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        so_d     = cur_bit;
        dat_en_d = 1'b1;
        if (accept) begin
          hr_d       = pi;
          hr_valid_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COMMIT: begin
        so_d     = commit_bit;
        dat_en_d = 1'b1;
        cnt_d    = '0;
        // Reloading SR here keeps dat_en high across back-to-back frames.
        if (hr_valid_q) begin
          sr_d       = hr_q;
          hr_valid_d = 1'b0;
          state_d    = ST_SHIFT;
        end else if (accept) begin
          sr_d    = pi;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      hr_q       <= '0;
      hr_valid_q <= 1'b0;
      so_q       <= 1'b0;
      dat_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      hr_q       <= hr_d;
      hr_valid_q <= hr_valid_d;
      so_q       <= so_d;
      dat_en_q   <= dat_en_d;
    end
  end

endmodule

// File: tb/tb_p2s_tx.sv
// Directed bench for p2s_tx: 8-bit instance with a receiver model and scoreboard,
// plus 2-bit and 16-bit instances for frame-length and loopback checks.
module tb_p2s_tx;
  import p2s_pkg::*;

  localparam int W = 8;
`ifdef P2S_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] pi;
  logic         pi_valid, pi_ready, so, dat_en, busy;
  p2s_state_e   state_dbg;

  logic [1:0]   pi_n;
  logic         pi_valid_n, pi_ready_n, so_n, dat_en_n, busy_n;
  p2s_state_e   state_dbg_n;

  logic [15:0]  pi_w;
  logic         pi_valid_w, pi_ready_w, so_w, dat_en_w, busy_w;
  p2s_state_e   state_dbg_w;

  p2s_tx #(.PORT_WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready),
    .so(so), .dat_en(dat_en), .busy(busy), .state_dbg(state_dbg)
  );

  p2s_tx #(.PORT_WIDTH(2)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .pi(pi_n), .pi_valid(pi_valid_n), .pi_ready(pi_ready_n),
    .so(so_n), .dat_en(dat_en_n), .busy(busy_n), .state_dbg(state_dbg_n)
  );

  p2s_tx #(.PORT_WIDTH(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .pi(pi_w), .pi_valid(pi_valid_w), .pi_ready(pi_ready_w),
    .so(so_w), .dat_en(dat_en_w), .busy(busy_w), .state_dbg(state_dbg_w)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word;
  logic [W-1:0] exp_w;
  int           rx_idx = 0;
  int           run_len = 0;
  int           max_run = 0;
  int           last_wait = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Receiver model: collects W bits while dat_en, the next dat_en cycle is the latch cycle.
  task automatic monitor();
    if (!rst_n) return;
    if (dat_en) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (rx_idx < W) begin
        rx_word[rx_idx] = so;
        rx_idx++;
      end else begin
        check("rx_frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("rx_word", rx_word, exp_w);
          check("rx_commit_bit", so, PAR_EN ? ^exp_w : 1'b0);
        end
        rx_idx = 0;
      end
    end else begin
      if (rx_idx != 0) check("rx_partial_frame", rx_idx, 0);
      rx_idx  = 0;
      run_len = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (pi_valid && pi_ready) exp_q.push_back(pi);
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic send(input logic [W-1:0] w);
    int guard;
    guard    = 0;
    pi       = w;
    pi_valid = 1'b1;
    while (!pi_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("send_timeout", pi_ready, 1);
    tick();
    pi_valid  = 1'b0;
    pi        = W'($urandom);
    last_wait = guard;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (busy && guard < 60) begin
      tick();
      guard++;
    end
    check("drain_idle", busy, 0);
  endtask

  task automatic sweep_one(input int w, input logic [15:0] word);
    logic [15:0] rx;
    logic        s_en, s_so, s_rdy;
    int          len, guard;
    rx    = '0;
    len   = 0;
    guard = 0;
    s_rdy = (w == 2) ? pi_ready_n : pi_ready_w;
    check("sweep_ready", s_rdy, 1);
    if (w == 2) begin pi_n = word[1:0]; pi_valid_n = 1'b1; end
    else begin pi_w = word; pi_valid_w = 1'b1; end
    tick();
    pi_valid_n = 1'b0;
    pi_valid_w = 1'b0;
    pi_n = 2'($urandom);
    pi_w = 16'($urandom);
    do begin
      tick();
      guard++;
      s_en = (w == 2) ? dat_en_n : dat_en_w;
      s_so = (w == 2) ? so_n : so_w;
      if (s_en) begin
        if (len < w) rx[len] = s_so;
        len++;
      end
    end while ((s_en || len == 0) && guard < 40);
    check("sweep_len", len, w + 1);
    check("sweep_word", rx, (w == 2) ? {14'b0, word[1:0]} : word);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] seq;
  int           en_cnt, busy_cnt, wait_cnt;

  initial begin
    rst_n = 1'b0;
    pi = '0; pi_valid = 1'b0;
    pi_n = '0; pi_valid_n = 1'b0;
    pi_w = '0; pi_valid_w = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_so", so, 0);
    check("rst_dat_en", dat_en, 0);
    check("rst_busy", busy, 0);
    check("rst_pi_ready", pi_ready, 1);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Single word A5: bit 0 appears one cycle after the accepting edge.
    send(8'hA5);
    check("a5_gap_dat_en", dat_en, 0);
    check("a5_gap_busy", busy, 1);
    seq = '0; en_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) seq[i] = so;
      if (dat_en) en_cnt++;
      if (i == 8) check("a5_commit_so", so, 0);
    end
    check("a5_bits", seq, 8'hA5);
    check("a5_en_cycles", en_cnt, 9);
    tick();
    check("a5_end_dat_en", dat_en, 0);
    check("a5_end_busy", busy, 0);

    // Back-to-back 3C, FF, 00: third word waits 8 cycles for HR to empty.
    max_run = 0;
    send(8'h3C);
    send(8'hFF);
    check("b2b_ready_low", pi_ready, 0);
    send(8'h00);
    check("b2b_wait", last_wait, 8);
    drain();
    check("b2b_run", max_run, 27);
    check("b2b_sb_empty", exp_q.size(), 0);

    // Backpressure: HR holds 81, pi_ready returns in the commit output cycle.
    send(8'h57);
    send(8'h81);
    check("bp_ready_drop", pi_ready, 0);
    pi = 8'h42; pi_valid = 1'b1;
    wait_cnt = 0;
    while (!pi_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check("bp_wait", wait_cnt, 8);
    check("bp_state_after_commit", state_dbg, ST_SHIFT);
    check("bp_commit_en", dat_en, 1);
    check("bp_commit_so", so, PAR_EN);
    send(8'h42);
    check("bp_no_extra_wait", last_wait, 0);
    drain();

    // Reset while bit 4 of F0 is on the line and HR holds 0F.
    send(8'hF0);
    send(8'h0F);
    repeat (4) tick();
    check("rst_pre_bit4", so, 1);
    check("rst_pre_en", dat_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_so", so, 0);
    check("rst_mid_dat_en", dat_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", pi_ready, 1);
    exp_q.delete();
    rx_idx = 0;
    run_len = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dat_en) en_cnt++;
      if (busy) busy_cnt++;
    end
    check("rst_after_dat_en", en_cnt, 0);
    check("rst_after_busy", busy_cnt, 0);

    // Commit-cycle bit: 07 has odd weight, 03 has even weight.
    send(8'h07);
    repeat (9) tick();
    check("p07_en", dat_en, 1);
    check("p07_so", so, PAR_EN);
    drain();
    send(8'h03);
    repeat (9) tick();
    check("p03_en", dat_en, 1);
    check("p03_so", so, 0);
    drain();

    // Width sweep on the 2-bit and 16-bit instances.
    for (int i = 0; i < 4; i++) sweep_one(2, 16'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++) sweep_one(16, 16'($urandom_range(0, 65535)));

    check("final_sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
